// File: rtl/edge_sobel_pkg.sv
// Shared image geometry, pixel type, FSM states and clip helper for the Sobel edge engine.
package edge_pkg;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam logic [13:0] LAST_IDX = 14'(IMG_W * IMG_H - 1);
  localparam logic [6:0]  LAST_COL = 7'(IMG_W - 1);
  localparam logic [7:0]  CLIP_MAX = 8'd255;

  typedef logic [7:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CALC,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic pixel_t clip_mag(input logic [11:0] mag);
    return (mag > {4'b0000, CLIP_MAX}) ? CLIP_MAX : mag[7:0];
  endfunction

endpackage

// File: rtl/edge_sobel_kernel.sv
// Combinational Sobel operator: 3x3 window (p0 in the low byte, p8 in the high byte)
// to a |Gx|+|Gy| magnitude clipped to 8 bits.
module sobel_kernel
  import edge_pkg::*;
(
  input  logic [71:0] win_i,
  output logic [7:0]  mag_o
);

  pixel_t p [9];

  for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
    assign p[gi] = win_i[gi*8 +: 8];
  end

  logic [9:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx, gy;
  logic [9:0]        ax, ay;
  logic [11:0]       mag;

  assign gx_pos = 10'(p[2]) + {1'b0, p[5], 1'b0} + 10'(p[8]);
  assign gx_neg = 10'(p[0]) + {1'b0, p[3], 1'b0} + 10'(p[6]);
  assign gy_pos = 10'(p[6]) + {1'b0, p[7], 1'b0} + 10'(p[8]);
  assign gy_neg = 10'(p[0]) + {1'b0, p[1], 1'b0} + 10'(p[2]);

  assign gx = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
  assign gy = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});

  // Each gradient is bounded by 1020 in magnitude, so the absolute value fits 10 bits.
  assign ax = gx[10] ? 10'(-gx) : gx[9:0];
  assign ay = gy[10] ? 10'(-gy) : gy[9:0];

  assign mag   = 12'(ax) + 12'(ay);
  assign mag_o = clip_mag(mag);

endmodule

// File: rtl/edge_sobel.sv
// Sobel edge map over a 128x128 source image; writes one result per pixel in raster order.
// Define EDGE_SOBEL_THRESH_EN to binarize the output against THRESH.
module edge_sobel
  import edge_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  output logic        busy,
  output logic [13:0] iaddr,
  input  logic [7:0]  idata,
  output logic [13:0] addr,
  output logic [7:0]  data_wr,
  output logic        wen
);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        wen_q, wen_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  data_wr_q, data_wr_d;
  logic [13:0] idx_q, idx_d;
  logic [1:0]  tap_r_q, tap_r_d;
  logic [1:0]  tap_c_q, tap_c_d;
  pixel_t      win_q [9];
  pixel_t      win_d [9];

  logic        shift_en;
  logic        fetch_wr;
  logic [7:0]  trow, tcol;
  logic        tap_in;
  pixel_t      tap_pix;
  logic [3:0]  tap_sel;
  logic [71:0] win_flat;
  logic [7:0]  mag;
  logic [7:0]  result;

  // Tap coordinates relative to the centre; a set bit 7 means the tap fell off the image.
  assign trow    = {1'b0, idx_q[13:7]} + {6'b0, tap_r_q} - 8'd1;
  assign tcol    = {1'b0, idx_q[6:0]}  + {6'b0, tap_c_q} - 8'd1;
  assign tap_in  = ~trow[7] & ~tcol[7];
  assign tap_pix = tap_in ? idata : 8'd0;
  assign tap_sel = {1'b0, tap_r_q, 1'b0} + {2'b00, tap_r_q} + {2'b00, tap_c_q};
  assign fetch_wr = (state_q == ST_FETCH);

  assign iaddr   = fetch_wr ? {trow[6:0], tcol[6:0]} : 14'd0;
  assign busy    = busy_q;
  assign wen     = wen_q;
  assign addr    = addr_q;
  assign data_wr = data_wr_q;

  for (genvar gi = 0; gi < 9; gi++) begin : g_win
    assign win_flat[gi*8 +: 8] = win_q[gi];
    if (gi % 3 == 2) begin : g_right
      assign win_d[gi] = (fetch_wr && tap_sel == 4'(gi)) ? tap_pix : win_q[gi];
    end else begin : g_shift
      assign win_d[gi] = (fetch_wr && tap_sel == 4'(gi)) ? tap_pix :
                         shift_en ? win_q[gi+1] : win_q[gi];
    end
  end

  sobel_kernel u_kernel (
    .win_i (win_flat),
    .mag_o (mag)
  );

`ifdef EDGE_SOBEL_THRESH_EN
  assign result = (mag >= THRESH) ? 8'hFF : 8'h00;
`else
  assign result = mag;
`endif

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    wen_d     = 1'b0;
    addr_d    = addr_q;
    data_wr_d = data_wr_q;
    idx_d     = idx_q;
    tap_r_d   = tap_r_q;
    tap_c_d   = tap_c_q;
    shift_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          state_d = ST_FETCH;
          busy_d  = 1'b1;
          idx_d   = 14'd0;
          tap_r_d = 2'd0;
          tap_c_d = 2'd0;
        end
      end
      ST_FETCH: begin
        if (tap_r_q == 2'd2) begin
          tap_r_d = 2'd0;
          if (tap_c_q == 2'd2) state_d = ST_CALC;
          else                 tap_c_d = tap_c_q + 2'd1;
        end else begin
          tap_r_d = tap_r_q + 2'd1;
        end
      end
      ST_CALC: begin
        state_d   = ST_WRITE;
        wen_d     = 1'b1;
        addr_d    = idx_q;
        data_wr_d = result;
      end
      ST_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_FETCH;
          idx_d   = idx_q + 14'd1;
          tap_r_d = 2'd0;
          // A new row needs the full 9-tap fetch; otherwise slide and read the right column.
          if (idx_q[6:0] == LAST_COL) begin
            tap_c_d = 2'd0;
          end else begin
            tap_c_d  = 2'd2;
            shift_en = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= 14'd0;
      data_wr_q <= 8'd0;
      idx_q     <= 14'd0;
      tap_r_q   <= 2'd0;
      tap_c_q   <= 2'd0;
      for (int i = 0; i < 9; i++) win_q[i] <= 8'd0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      data_wr_q <= data_wr_d;
      idx_q     <= idx_d;
      tap_r_q   <= tap_r_d;
      tap_c_q   <= tap_c_d;
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

endmodule
